// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Handshake and pipeline-register bundle of the fetch stage:
//                downstream control, instruction-memory req/ack bus and the
//                IF/ID outputs consumed by decode.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;

   // Fetch stage side
   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
      output imem_req_o, imem_addr_o, id_pc_o, id_inst_o, id_valid_o
   );

   // Environment side: memory, decode and the change-of-flow source
   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
      input  imem_req_o, imem_addr_o, id_pc_o, id_inst_o, id_valid_o
   );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Owns the PC, keeps one request
//                outstanding to instruction memory, buffers one fetched word
//                while decode is stalled and squashes wrong-path fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire logic   clk,
   input  wire logic   rst,
   if_stage_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] buf_pc;
   logic [31:0] buf_inst;
   logic        kill;
   logic [31:0] kill_pc;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;

   logic [31:0] pc_inc;
   logic [31:0] squash_pc;
   logic        deliver_ack;
   logic        deliver_buf;

   assign pc_inc    = pc + 32'd4;
   // Where to resume after a squashed ack: a live redirect beats a stored one
   assign squash_pc = bus.redirect_i ? bus.redirect_pc_i : kill_pc;

   // An ack is delivered only when it is on the correct path and decode can take it
   assign deliver_ack = (state == S_REQ) && bus.imem_ack_i && !kill &&
                        !bus.redirect_i && !bus.stall_i;
   assign deliver_buf = (state == S_FULL) && !bus.redirect_i && !bus.stall_i;

   assign bus.imem_req_o  = fetch_req;
   assign bus.imem_addr_o = fetch_addr;
   assign bus.id_pc_o     = id_pc;
   assign bus.id_inst_o   = id_inst;
   assign bus.id_valid_o  = id_valid;

   // Fetch FSM: PC, hold buffer, kill tracking and the registered memory request
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         buf_pc     <= 32'h0;
         buf_inst   <= 32'h0;
         kill       <= 1'b0;
         kill_pc    <= 32'h0;
         fetch_req  <= 1'b0;
         fetch_addr <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               state     <= S_REQ;
               fetch_req <= 1'b1;
               if (bus.redirect_i) begin
                  pc         <= bus.redirect_pc_i;
                  fetch_addr <= bus.redirect_pc_i;
               end else begin
                  fetch_addr <= pc;
               end
            end
            S_REQ: begin
               if (bus.imem_ack_i) begin
                  if (kill || bus.redirect_i) begin
                     // Wrong-path word: drop it and start the target fetch
                     pc         <= squash_pc;
                     fetch_addr <= squash_pc;
                     kill       <= 1'b0;
                  end else if (!bus.stall_i) begin
                     pc         <= pc_inc;
                     fetch_addr <= pc_inc;
                  end else begin
                     buf_pc     <= pc;
                     buf_inst   <= bus.imem_rdata_i;
                     pc         <= pc_inc;
                     state      <= S_FULL;
                     fetch_req  <= 1'b0;
                     fetch_addr <= 32'h0;
                  end
               end else if (bus.redirect_i) begin
                  // The request cannot be withdrawn; remember to squash its ack
                  kill    <= 1'b1;
                  kill_pc <= bus.redirect_pc_i;
               end
            end
            S_FULL: begin
               if (bus.redirect_i) begin
                  pc         <= bus.redirect_pc_i;
                  state      <= S_REQ;
                  fetch_req  <= 1'b1;
                  fetch_addr <= bus.redirect_pc_i;
               end else if (!bus.stall_i) begin
                  state      <= S_REQ;
                  fetch_req  <= 1'b1;
                  fetch_addr <= pc;
               end
            end
            default: begin
               state      <= S_IDLE;
               fetch_req  <= 1'b0;
               fetch_addr <= 32'h0;
            end
         endcase
      end
   end

   // IF/ID register: redirect bubbles even under stall, stall holds, else deliver or bubble
   always_ff @(posedge clk) begin
      if (rst || bus.redirect_i) begin
         id_pc    <= 32'h0;
         id_inst  <= 32'h0;
         id_valid <= 1'b0;
      end else if (!bus.stall_i) begin
         if (deliver_ack) begin
            id_pc    <= pc;
            id_inst  <= bus.imem_rdata_i;
            id_valid <= 1'b1;
         end else if (deliver_buf) begin
            id_pc    <= buf_pc;
            id_inst  <= buf_inst;
            id_valid <= 1'b1;
         end else begin
            id_pc    <= 32'h0;
            id_inst  <= 32'h0;
            id_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues one-outstanding requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register consumed by the decode stage. It absorbs variable memory latency, honours downstream stalls via a one-entry hold buffer, and redirects to a new PC on branch or exception. Wrong-path fetches are discarded. There is no delay slot.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- stall_i  in  1  downstream stall; IF/ID outputs must hold.
- redirect_i  in  1  change of flow (taken branch, jump, exception).
- redirect_pc_i  in  32  target of redirect; word-aligned.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address.
- imem_ack_i  in  1  request completed; rdata valid this cycle.
- imem_rdata_i  in  32  fetched instruction word.
- id_pc_o  out  32  PC of instruction presented to decode.
- id_inst_o  out  32  instruction presented to decode; 32'h0 (NOP) when invalid.
- id_valid_o  out  1  id_inst_o is a real instruction.

## Operation
- Registers:
  - pc (32);
  - state ∈ {S_IDLE, S_REQ, S_FULL};
  - buf_pc / buf_inst (hold buffer);
  - kill flag;
  - kill_pc (32).
- Reset: pc=RESET_PC, state=S_IDLE, kill=0, buffer cleared. id_pc_o=0, id_inst_o=0, id_valid_o=0, imem_req_o=0, imem_addr_o=0.
- S_IDLE: req=0. Next state S_REQ unconditionally. A redirect here loads pc=redirect_pc_i.
- S_REQ: imem_req_o=1, imem_addr_o=pc. pc is frozen until ack; address stays stable while req is high.
  - Ack with kill=1, or redirect_i this cycle: discard rdata, pc = redirect_pc_i if redirect_i, else kill_pc; kill=0; stay S_REQ.
  - Ack, no stall: IF/ID ← {pc, rdata, valid=1}; pc += 4; stay S_REQ.
  - Ack, stall: buffer ← {pc, rdata}; pc += 4; go S_FULL.
  - No ack, redirect_i: kill=1, kill_pc=redirect_pc_i. A later redirect before ack overwrites kill_pc.
- S_FULL: imem_req_o=0.
  - Redirect_i: drop buffer; pc=redirect_pc_i; go S_REQ.
  - Else !stall_i: IF/ID ← buffer with valid=1; go S_REQ.
  - Else hold.
- IF/ID register update priority, highest first:
  1. rst: clear.
  2. redirect_i: bubble (pc=0, inst=0, valid=0), even when stall_i=1.
  3. stall_i: hold.
  4. Deliver, from ack or buffer.
  5. Otherwise bubble.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of pc are always 0.

## Timing
- Zero-wait memory (ack in the request cycle): one instruction per cycle. id_* updates on the edge that ends the ack cycle.
- Fetch-to-decode latency: 1 cycle after ack.
- First request: the cycle after rst deasserts is S_IDLE; imem_req_o rises the following cycle.
- Redirect penalty with zero-wait memory: 1 bubble. Target request is issued the cycle after redirect_i, or after the outstanding ack when kill is set.
- A killed in-flight request never reaches id_*. It still occupies the memory until acked; no request is abandoned.
- rst mid-request: state goes to S_IDLE and req drops on the next edge. Memory tolerates the abandoned request.

## Test plan
- Reset, RESET_PC=32'h100, ack tied to 1 with rdata=addr^32'hA5A5_0000 -> id_pc_o sequence 0x100, 0x104, 0x108 on consecutive cycles; id_valid_o=1 from the 3rd cycle after reset release.
- Ack delayed 2 cycles per request -> imem_addr_o stable during wait; id_valid_o pulses one cycle in three; bubbles carry id_inst_o=0.
- stall_i high for 4 cycles while ack arrives -> state S_FULL, req=0, id_* unchanged. On release, id_* shows the buffered {pc, inst}, and the next request addr = buffered pc+4.
- redirect_i to 0x400 while a request to 0x20 is waiting -> 0x20's data is discarded at ack; next req addr=0x400; id_valid_o=0 until 0x400 delivers.
- redirect_i and stall_i high together in S_FULL -> id_valid_o=0 next cycle, buffer dropped, req to redirect_pc_i next cycle.
- pc=32'hFFFF_FFFC fetched -> next req addr 32'h0000_0000.
